// File: rtl/fifo_wide2narrow_unpacker.sv
// fifo_wide2narrow_unpacker
//   Pops wide words from a first-word-fall-through FIFO and re-serialises
//   each one as RATIO = WIDE_WIDTH/NARROW_WIDTH narrow slices on a
//   valid/ready stream. One slice per clock is sustained, with no bubble
//   between consecutive wide words.
//
// Build option:
//   UNPACKER_MSB_FIRST_EN  when defined, the MSB slice of each word is sent
//                          first. Otherwise slice 0 (the LSBs) goes first.
//                          Handshake, latency and counter are identical.
//
// Ports:
//   clk            sole clock, rising edge
//   rstn           asynchronous active-low reset
//   fifo_rd_ena    pop strobe to the FWFT FIFO
//   fifo_rd_dat    FWFT head word, valid while fifo_rd_empty=0
//   fifo_rd_empty  FIFO empty flag
//   m_valid        output slice valid
//   m_ready        downstream accept
//   m_data         current slice
//   m_last         final slice of the current wide word
//   word_cnt       wide words popped since reset (wraps)
module fifo_wide2narrow_unpacker #(
    parameter int WIDE_WIDTH   = 128,
    parameter int NARROW_WIDTH = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    fifo_rd_ena,
    input  logic [WIDE_WIDTH-1:0]   fifo_rd_dat,
    input  logic                    fifo_rd_empty,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [NARROW_WIDTH-1:0] m_data,
    output logic                    m_last,
    output logic [CNT_WIDTH-1:0]    word_cnt
);
    localparam int RATIO = WIDE_WIDTH / NARROW_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(RATIO - 1);

    // Slice index wraps naturally only when RATIO is a power of two.
    generate
        if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * NARROW_WIDTH != WIDE_WIDTH) begin : g_bad_ratio
            $error("WIDE_WIDTH/NARROW_WIDTH must be an integer power of two >= 2");
        end
    endgenerate

    logic                                  hold_valid;
    logic [RATIO-1:0][NARROW_WIDTH-1:0]    hold;
    idx_t                                  idx;
    idx_t                                  sel;
    logic                                  accept;
    logic                                  last_acc;
    logic                                  pop;

    assign accept   = hold_valid & m_ready;
    assign last_acc = accept & (idx == IDX_LAST);

    // Refill when idle, or in the same cycle the last slice leaves so the
    // next word's slice 0 follows with no idle cycle. Gated by rstn so no
    // word is consumed while the block is held in reset.
    assign pop         = rstn & ~fifo_rd_empty & (~hold_valid | last_acc);
    assign fifo_rd_ena = pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_valid <= 1'b0;
            hold       <= '0;
            idx        <= '0;
            word_cnt   <= '0;
        end else begin
            if (pop) begin
                hold       <= fifo_rd_dat;
                idx        <= '0;
                hold_valid <= 1'b1;
                word_cnt   <= word_cnt + CNT_WIDTH'(1);
            end else if (last_acc) begin
                hold_valid <= 1'b0;
                idx        <= '0;
            end else if (accept) begin
                idx        <= idx + idx_t'(1);
            end
        end
    end

    // RATIO is a power of two, so RATIO-1-idx is just the bitwise inverse.
`ifdef UNPACKER_MSB_FIRST_EN
    assign sel = ~idx;
`else
    assign sel = idx;
`endif

    assign m_valid = hold_valid;
    assign m_data  = hold[sel];
    assign m_last  = hold_valid & (idx == IDX_LAST);

endmodule

// File: tb/tb_fifo_wide2narrow_unpacker.sv
module tb_fifo_wide2narrow_unpacker;
    localparam int WW = 128;
    localparam int NW = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rstn;
    logic          fifo_rd_ena;
    logic [WW-1:0] fifo_rd_dat;
    logic          fifo_rd_empty;
    logic          m_valid;
    logic          m_ready;
    logic [NW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] word_cnt;

    fifo_wide2narrow_unpacker #(.WIDE_WIDTH(WW), .NARROW_WIDTH(NW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .fifo_rd_ena(fifo_rd_ena), .fifo_rd_dat(fifo_rd_dat), .fifo_rd_empty(fifo_rd_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [WW-1:0] mem [16];
    logic [7:0]    wr_ptr;
    logic [7:0]    rd_ptr;
    int            pop_cnt;
    int            underflow;

    assign fifo_rd_empty = (wr_ptr == rd_ptr);
    assign fifo_rd_dat   = mem[rd_ptr[3:0]];

    initial begin
        rd_ptr    = '0;
        pop_cnt   = 0;
        underflow = 0;
    end

    always @(posedge clk) begin
        if (fifo_rd_ena) begin
            if (fifo_rd_empty) underflow <= underflow + 1;
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input logic [WW-1:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    function automatic logic [WW-1:0] mk_word(input logic [NW-1:0] base);
        logic [WW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*NW +: NW] = base + NW'(i);
        return w;
    endfunction

    // Expected value of the k-th emitted slice of word mk_word(base)
    function automatic logic [NW-1:0] sl(input logic [NW-1:0] base, input int k);
`ifdef UNPACKER_MSB_FIRST_EN
        return base + NW'(7 - k);
`else
        return base + NW'(k);
`endif
    endfunction

    // At a negedge with slice 0 of word 'base' presented and m_ready=1,
    // check all eight slices; leaves at the negedge after the last accept.
    task automatic expect_word(input string tag, input logic [NW-1:0] base);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_valid"}, WW'(m_valid), WW'(1));
            chk({tag, "_data"},  WW'(m_data),  WW'(sl(base, k)));
            chk({tag, "_last"},  WW'(m_last),  WW'(k == 7));
            @(negedge clk);
        end
    endtask

    initial begin
        wr_ptr  = '0;
        n_chk   = 0;
        n_pass  = 0;
        rstn    = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state; word waiting in FIFO must not be popped during reset
        push(mk_word(16'h0000));
        #1;
        chk("rst_valid", WW'(m_valid), WW'(0));
        chk("rst_last",  WW'(m_last),  WW'(0));
        chk("rst_data",  WW'(m_data),  WW'(0));
        chk("rst_cnt",   WW'(word_cnt), WW'(0));
        chk("rst_ena",   WW'(fifo_rd_ena), WW'(0));

        // Single word
        @(negedge clk);
        rstn    = 1'b1;
        m_ready = 1'b1;
        #1 chk("s1_ena", WW'(fifo_rd_ena), WW'(1));
        @(negedge clk);
        expect_word("s1", 16'h0000);
        chk("s1_idle", WW'(m_valid), WW'(0));
        chk("s1_cnt",  WW'(word_cnt), WW'(1));
        chk("s1_pops", WW'(pop_cnt), WW'(1));

        // Back-to-back: 16 valid cycles, refill pop on first word's last accept
        push(mk_word(16'h0010));
        push(mk_word(16'h0020));
        #1 chk("b2b_ena0", WW'(fifo_rd_ena), WW'(1));
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_valid", WW'(m_valid), WW'(1));
            chk("b2b_data",  WW'(m_data),  WW'(sl((k < 8) ? 16'h0010 : 16'h0020, k % 8)));
            chk("b2b_last",  WW'(m_last),  WW'(k % 8 == 7));
            chk("b2b_ena",   WW'(fifo_rd_ena), WW'(k == 7));
            @(negedge clk);
        end
        chk("b2b_idle", WW'(m_valid), WW'(0));
        chk("b2b_cnt",  WW'(word_cnt), WW'(3));
        chk("b2b_pops", WW'(pop_cnt), WW'(3));

        // Backpressure: next word waits in FIFO, must not be popped early
        begin
            int pat [12] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1};
            int exp_idx = 0;
            int c = 0;
            m_ready = 1'b0;
            push(mk_word(16'h0030));
            @(negedge clk);
            push(mk_word(16'h0040));
            while (exp_idx < 8 && c < 40) begin
                chk("bp_valid", WW'(m_valid), WW'(1));
                chk("bp_data",  WW'(m_data),  WW'(sl(16'h0030, exp_idx)));
                chk("bp_last",  WW'(m_last),  WW'(exp_idx == 7));
                m_ready = pat[c % 12][0];
                #1 chk("bp_ena", WW'(fifo_rd_ena), WW'(m_ready && exp_idx == 7));
                if (m_ready) exp_idx++;
                c++;
                @(negedge clk);
            end
            m_ready = 1'b1;
            expect_word("bp2", 16'h0040);
            chk("bp_cnt",  WW'(word_cnt), WW'(5));
            chk("bp_pops", WW'(pop_cnt), WW'(5));
        end

        // Empty gap between words
        push(mk_word(16'h0050));
        #1 chk("gap_ena0", WW'(fifo_rd_ena), WW'(1));
        @(negedge clk);
        expect_word("gap1", 16'h0050);
        for (int k = 0; k < 5; k++) begin
            chk("gap_valid", WW'(m_valid), WW'(0));
            chk("gap_ena",   WW'(fifo_rd_ena), WW'(0));
            @(negedge clk);
        end
        push(mk_word(16'h0060));
        #1 chk("gap_ena1", WW'(fifo_rd_ena), WW'(1));
        @(negedge clk);

        // Reset mid-word: accept slices 0..3 of this word then reset
        for (int k = 0; k < 4; k++) begin
            chk("mid_valid", WW'(m_valid), WW'(1));
            chk("mid_data",  WW'(m_data),  WW'(sl(16'h0060, k)));
            @(negedge clk);
        end
        chk("mid_data4", WW'(m_data), WW'(sl(16'h0060, 4)));
        rstn = 1'b0;
        push(mk_word(16'h0070));
        #1;
        chk("mrst_valid", WW'(m_valid), WW'(0));
        chk("mrst_last",  WW'(m_last),  WW'(0));
        chk("mrst_data",  WW'(m_data),  WW'(0));
        chk("mrst_cnt",   WW'(word_cnt), WW'(0));
        chk("mrst_ena",   WW'(fifo_rd_ena), WW'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("mrst_ena1", WW'(fifo_rd_ena), WW'(1));
        @(negedge clk);
        expect_word("post", 16'h0070);
        chk("post_idle", WW'(m_valid), WW'(0));
        chk("post_cnt",  WW'(word_cnt), WW'(1));
        chk("pops_total", WW'(pop_cnt), WW'(8));
        chk("underflow", WW'(underflow), WW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fifo_wide2narrow_unpacker.md
Name: fifo_wide2narrow_unpacker

Overview:
- Downstream consumer of the wide first-word-fall-through FIFO output. The FIFO side is the rd_ena / rd_dat / rd_empty interface of the narrow-to-wide FIFO adapter.
- Pops one wide word at a time and emits it as RATIO narrow slices on a valid/ready stream.
- Sustains one narrow slice per clock with no bubble between wide words.
- Used wherever packed wide data must be re-serialised to the original sample width.

Parameters:
- WIDE_WIDTH, 128, width of the FIFO read word.
- NARROW_WIDTH, 16, width of each output slice. RATIO = WIDE_WIDTH/NARROW_WIDTH must be an integer power of two, >= 2.
- CNT_WIDTH, 32, width of the popped-word counter.

Ports:
- clk  in  1  sole clock, all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- fifo_rd_ena  out  1  pop strobe to the FWFT FIFO.
- fifo_rd_dat  in  WIDE_WIDTH  FWFT head word, valid while fifo_rd_empty=0.
- fifo_rd_empty  in  1  FIFO empty flag.
- m_valid  out  1  output slice valid.
- m_ready  in  1  downstream accept.
- m_data  out  NARROW_WIDTH  current slice.
- m_last  out  1  high on the final slice of a wide word.
- word_cnt  out  CNT_WIDTH  number of wide words popped since reset.

Behaviour:
- Reset (async, rstn=0):
  - hold register and slice index cleared; m_valid=0, m_last=0, m_data=0, word_cnt=0.
  - fifo_rd_ena=0 while rstn=0.
- State:
  - hold_valid flag, WIDE_WIDTH hold register, log2(RATIO)-bit slice index idx.
  - EMPTY state = hold_valid=0; ACTIVE state = hold_valid=1.
- Slice accept: accept = m_valid & m_ready.
- Last slice: last_acc = accept & (idx == RATIO-1).
- Pop rule (combinational): fifo_rd_ena = ~fifo_rd_empty & (~hold_valid | last_acc).
  - Never asserted while fifo_rd_empty=1.
  - At most one pop per cycle.
- On fifo_rd_ena:
  - hold <= fifo_rd_dat, idx <= 0, hold_valid <= 1, word_cnt <= word_cnt+1.
  - word_cnt wraps modulo 2^CNT_WIDTH.
- On last_acc without a pop: hold_valid <= 0 (return to EMPTY), idx <= 0.
- On accept, not last: idx <= idx+1; hold unchanged.
- Outputs:
  - m_valid = hold_valid.
  - m_data = hold[idx*NARROW_WIDTH +: NARROW_WIDTH]; slice 0 is the LSB slice.
  - m_last = hold_valid & (idx == RATIO-1).
  - m_data, m_last and idx are held stable while m_valid=1 & m_ready=0 (AXI-stream rules).
- Latency: fifo_rd_empty falls in cycle N with the unpacker EMPTY → pop in cycle N → m_valid=1 from cycle N+1.
- Back-to-back: last slice accepted and FIFO non-empty → pop in the same cycle. Slice 0 of the next word is presented the next cycle, with no idle cycle.
- FIFO empty at last_acc: m_valid falls the next cycle. The unpacker waits in EMPTY, then follows the latency rule above.
- m_ready held low indefinitely: no further pops, so the FIFO fills and its upstream full flag asserts. No data loss.
- Reset mid-word: the remaining slices of the held word are discarded. That word has already been popped and is not re-read.
- m_ready may toggle every cycle. Throughput equals the number of accept cycles.

Optional Feature:
- Macro: UNPACKER_MSB_FIRST_EN.
- Defined: slice order reversed, so m_data = hold[(RATIO-1-idx)*NARROW_WIDTH +: NARROW_WIDTH] and the MSB slice goes out first. m_last still marks the RATIO-th slice.
- Not defined: LSB-first order as above.
- Handshake, latency and counter are identical in both builds.

Test Plan:
- Single word: FIFO holds 0x0007_0006_0005_0004_0003_0002_0001_0000, m_ready=1 → m_valid from cycle N+1; m_data 0x0000..0x0007 on 8 consecutive cycles; m_last only on 0x0007; one fifo_rd_ena pulse; word_cnt=1; m_valid=0 after.
- Back-to-back: two words preloaded, m_ready=1 → 16 consecutive valid cycles with no gap; fifo_rd_ena pulses on cycle N and on the cycle of the first word's last accept; word_cnt=2.
- Backpressure: m_ready pattern 1,0,0,1,0,1... → m_data/m_last stable during every m_ready=0 cycle; all 8 slices delivered in order; no extra pops.
- Empty gap: one word; FIFO kept empty 5 cycles after its last slice; second word then written → m_valid=0 during the gap; second word's slice 0 appears one cycle after fifo_rd_empty falls.
- Reset mid-word: rstn pulsed low after slice 3 is accepted → outputs and word_cnt=0 immediately (async); after release, the next FIFO word starts at slice 0.
- MSB-first build (UNPACKER_MSB_FIRST_EN defined): same word as the first scenario → m_data order 0x0007 down to 0x0000; m_last on 0x0000.
